bus_rr_ooo: RTL and testbench

- Parametrised successor to the simulation shared bus: N hosts, M devices, address-decoded, one request accepted per cycle.
- Adds selectable fixed-priority or round-robin arbitration.
- Adds multiple outstanding transactions through an in-order response-routing FIFO.
- Unmapped addresses get a generated error response. Used by sim tops (core I/D, test utility, RAM, peripherals).

---
 rtl/bus_rr_pkg.sv | 16 +
 rtl/bus_route_fifo.sv | 43 ++++
 rtl/bus_rr_ooo.sv | 112 +++++++++++
 tb/tb_bus_rr_ooo.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/bus_rr_pkg.sv
// bus_rr_pkg: arbitration modes and route-entry type shared by the bus and its response FIFO
package bus_rr_pkg;
  typedef enum logic {ArbFixed, ArbRoundRobin} arb_mode_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int MaxHosts = 16;
  localparam int MaxDevices = 16;
  localparam int HostIdxW = idx_w(MaxHosts);
  localparam int DevIdxW = idx_w(MaxDevices);
  typedef struct packed {
    logic [HostIdxW-1:0] host;
    logic [DevIdxW-1:0]  dev;
    logic                decode_err;
  } route_entry_t;
endpackage

// File: rtl/bus_route_fifo.sv
// bus_route_fifo: in-order FIFO of route entries.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i write side;
// pop_i/data_o read side (data_o shows the head); full_o, empty_o, count_o status.
module bus_route_fifo
  import bus_rr_pkg::*;
#(
  parameter int Depth = 2,
  localparam int CW = $clog2(Depth + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  route_entry_t  data_i,
  input  logic          pop_i,
  output route_entry_t  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = idx_w(Depth);
  route_entry_t r_mem [Depth];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_push, w_pop;
  assign full_o  = r_count == CW'(Depth);
  assign empty_o = r_count == '0;
  assign count_o = r_count;
  assign data_o  = r_mem[r_rd];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  always_ff @(posedge clk_i) if (w_push) r_mem[r_wr] <= data_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == PW'(Depth - 1)) ? '0 : r_wr + 1'b1;
      if (w_pop) r_rd <= (r_rd == PW'(Depth - 1)) ? '0 : r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/bus_rr_ooo.sv
// bus_rr_ooo: N-host / M-device address-decoded bus, one grant per cycle, in-order responses.
// Ports: host_* request/grant/response per host; device_* request/response per device;
// cfg_device_addr_base/mask give each device's decode window; clk_i, rst_ni async active-low.
module bus_rr_ooo
  import bus_rr_pkg::*;
#(
  parameter int        NrHosts        = 3,
  parameter int        NrDevices      = 2,
  parameter int        DataWidth      = 32,
  parameter int        AddressWidth   = 32,
  parameter arb_mode_e ArbMode        = ArbFixed,
  parameter int        MaxOutstanding = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NrHosts-1:0]                      host_req_i,
  output logic [NrHosts-1:0]                      host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]    host_addr_i,
  input  logic [NrHosts-1:0]                      host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]     host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]       host_wdata_i,
  output logic [NrHosts-1:0]                      host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]       host_rdata_o,
  output logic [NrHosts-1:0]                      host_err_o,
  output logic [NrDevices-1:0]                    device_req_o,
  output logic [NrDevices-1:0][AddressWidth-1:0]  device_addr_o,
  output logic [NrDevices-1:0]                    device_we_o,
  output logic [NrDevices-1:0][DataWidth/8-1:0]   device_be_o,
  output logic [NrDevices-1:0][DataWidth-1:0]     device_wdata_o,
  input  logic [NrDevices-1:0]                    device_rvalid_i,
  input  logic [NrDevices-1:0][DataWidth-1:0]     device_rdata_i,
  input  logic [NrDevices-1:0]                    device_err_i,
  input  logic [NrDevices-1:0][AddressWidth-1:0]  cfg_device_addr_base,
  input  logic [NrDevices-1:0][AddressWidth-1:0]  cfg_device_addr_mask
);
  localparam int HW = idx_w(NrHosts);
  localparam int DW = idx_w(NrDevices);
  localparam int CW = $clog2(MaxOutstanding + 1);
  logic [HW-1:0] r_ptr, w_base, w_idx, w_cand, w_hh;
  logic [DW-1:0] w_dev, w_hd;
  logic w_grant, w_hit, w_pop, w_empty, w_full;
  logic [CW-1:0] w_count;
  route_entry_t w_push_entry, w_head;
  // Fixed priority is round-robin with the pointer pinned to the last host.
  assign w_base = (ArbMode == ArbRoundRobin) ? r_ptr : HW'(NrHosts - 1);
  always_comb begin
    w_cand = '0;
    w_idx  = '0;
    for (int k = NrHosts; k >= 1; k--) begin
      w_idx = HW'((int'(w_base) + k) % NrHosts);
      if (host_req_i[w_idx]) w_cand = w_idx;
    end
  end
  // Descending scan so the lowest matching device index wins.
  always_comb begin
    w_hit = 1'b0;
    w_dev = '0;
    for (int d = NrDevices - 1; d >= 0; d--)
      if ((host_addr_i[w_cand] & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
        w_hit = 1'b1;
        w_dev = DW'(d);
      end
  end
  // Uses the registered count, so a same-cycle pop never frees a slot for this grant.
  assign w_grant = |host_req_i && (w_count < CW'(MaxOutstanding));
  assign device_addr_o  = {NrDevices{host_addr_i[w_cand]}};
  assign device_we_o    = {NrDevices{host_we_i[w_cand]}};
  assign device_be_o    = {NrDevices{host_be_i[w_cand]}};
  assign device_wdata_o = {NrDevices{host_wdata_i[w_cand]}};
  assign w_push_entry   = '{host: HostIdxW'(w_cand), dev: DevIdxW'(w_dev), decode_err: !w_hit};
  assign w_hh = HW'(w_head.host);
  assign w_hd = DW'(w_head.dev);
  always_comb begin
    host_gnt_o    = '0;
    device_req_o  = '0;
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    w_pop         = 1'b0;
    host_gnt_o[w_cand]  = w_grant;
    device_req_o[w_dev] = w_grant && w_hit;
    if (!w_empty && w_head.decode_err) begin
      host_rvalid_o[w_hh] = 1'b1;
      host_err_o[w_hh]    = 1'b1;
      w_pop               = 1'b1;
    end else if (!w_empty && device_rvalid_i[w_hd]) begin
      host_rvalid_o[w_hh] = 1'b1;
      host_err_o[w_hh]    = device_err_i[w_hd];
      host_rdata_o[w_hh]  = device_rdata_i[w_hd];
      w_pop               = 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ptr <= HW'(NrHosts - 1);
    else if (w_grant) r_ptr <= w_cand;
  end
  bus_route_fifo #(.Depth(MaxOutstanding)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_grant),
    .data_i  (w_push_entry),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );
  // A device response is only legal from the device the head entry is waiting on.
  always @(posedge clk_i)
    if (rst_ni && |device_rvalid_i)
      assert (!w_empty && !w_head.decode_err && device_rvalid_i == (NrDevices'(1) << w_hd));
endmodule

// File: tb/tb_bus_rr_ooo.sv
// tb_bus_rr_ooo: directed table and sequence checks for bus_rr_ooo in fixed and round-robin modes
module tb_bus_rr_ooo;
  import bus_rr_pkg::*;
  logic clk = 1'b0;
  logic rst_ni;
  logic [2:0] req, rr_req;
  logic [2:0][31:0] addr, wdata;
  logic [2:0] we;
  logic [2:0][3:0] be;
  logic [1:0] drv;
  logic [1:0][31:0] drdata;
  logic [1:0] derr;
  logic [1:0][31:0] base, mask;
  logic [2:0] gnt, rvalid, err;
  logic [2:0][31:0] rdata;
  logic [1:0] dreq, dwe;
  logic [1:0][31:0] daddr, dwdata;
  logic [1:0][3:0] dbe;
  logic [2:0] rr_gnt, rr_rvalid, rr_err;
  logic [2:0][31:0] rr_rdata;
  logic [1:0] rr_dreq, rr_dwe;
  logic [1:0][31:0] rr_daddr, rr_dwdata;
  logic [1:0][3:0] rr_dbe;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  bus_rr_ooo u_fix (
    .clk_i(clk), .rst_ni(rst_ni), .host_req_i(req), .host_gnt_o(gnt), .host_addr_i(addr),
    .host_we_i(we), .host_be_i(be), .host_wdata_i(wdata), .host_rvalid_o(rvalid),
    .host_rdata_o(rdata), .host_err_o(err), .device_req_o(dreq), .device_addr_o(daddr),
    .device_we_o(dwe), .device_be_o(dbe), .device_wdata_o(dwdata), .device_rvalid_i(drv),
    .device_rdata_i(drdata), .device_err_i(derr), .cfg_device_addr_base(base),
    .cfg_device_addr_mask(mask)
  );
  bus_rr_ooo #(.ArbMode(ArbRoundRobin), .MaxOutstanding(8)) u_rr (
    .clk_i(clk), .rst_ni(rst_ni), .host_req_i(rr_req), .host_gnt_o(rr_gnt), .host_addr_i(addr),
    .host_we_i(we), .host_be_i(be), .host_wdata_i(wdata), .host_rvalid_o(rr_rvalid),
    .host_rdata_o(rr_rdata), .host_err_o(rr_err), .device_req_o(rr_dreq), .device_addr_o(rr_daddr),
    .device_we_o(rr_dwe), .device_be_o(rr_dbe), .device_wdata_o(rr_dwdata), .device_rvalid_i(2'b00),
    .device_rdata_i(drdata), .device_err_i(derr), .cfg_device_addr_base(base),
    .cfg_device_addr_mask(mask)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  typedef struct {
    logic [2:0]  req;
    logic [31:0] a0, a1, a2;
    logic [2:0]  gnt;
    logic [1:0]  dreq;
    logic [31:0] daddr;
  } vec_t;
  vec_t tbl [7];
  initial begin
    tbl[0] = '{3'b101, 32'h100,   32'h0,     32'h200,   3'b001, 2'b01, 32'h100};
    tbl[1] = '{3'b110, 32'h0,     32'h20004, 32'h100,   3'b010, 2'b10, 32'h20004};
    tbl[2] = '{3'b100, 32'h0,     32'h0,     32'h30000, 3'b100, 2'b00, 32'h0};
    tbl[3] = '{3'b000, 32'h0,     32'h0,     32'h0,     3'b000, 2'b00, 32'h0};
    tbl[4] = '{3'b111, 32'h2FFFF, 32'h0,     32'h0,     3'b001, 2'b10, 32'h2FFFF};
    tbl[5] = '{3'b010, 32'h0,     32'hFFFF,  32'h0,     3'b010, 2'b01, 32'hFFFF};
    tbl[6] = '{3'b100, 32'h0,     32'h0,     32'h10000, 3'b100, 2'b00, 32'h0};
    rst_ni = 1'b0; req = '0; rr_req = '0; addr = '0; wdata = '0; we = '0; be = '1;
    drv = '0; drdata = '0; derr = '0;
    base[0] = 32'h0;     mask[0] = 32'hFFFF_0000;
    base[1] = 32'h20000; mask[1] = 32'hFFFF_0000;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_dreq", 32'(dreq), 0);
    chk("rst_rdata0", rdata[0], 0);
    rst_ni = 1'b1;
    // combinational arbitration/decode rows; request dropped before the clock edge
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req = tbl[i].req; addr[0] = tbl[i].a0; addr[1] = tbl[i].a1; addr[2] = tbl[i].a2;
      #1;
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_dreq", i), 32'(dreq), 32'(tbl[i].dreq));
      if (tbl[i].dreq != 0) chk($sformatf("tbl%0d_daddr", i), daddr[tbl[i].dreq[1]], tbl[i].daddr);
      #1 req = '0;
    end
    // fixed priority: hosts 0 and 2 to RAM
    @(negedge clk); req = 3'b101; addr[0] = 32'h40; addr[2] = 32'h80;
    #1 chk("fp_gnt0", 32'(gnt), 32'b001); chk("fp_dreq", 32'(dreq), 32'b01);
    chk("fp_daddr0", daddr[0], 32'h40); chk("fp_rv_none", 32'(rvalid), 0);
    @(negedge clk); req = 3'b100; drv = 2'b01; drdata[0] = 32'hAAAA;
    #1 chk("fp_gnt2", 32'(gnt), 32'b100); chk("fp_rv0", 32'(rvalid), 32'b001);
    chk("fp_rd0", rdata[0], 32'hAAAA); chk("fp_daddr2", daddr[0], 32'h80);
    @(negedge clk); req = '0; drdata[0] = 32'hBBBB;
    #1 chk("fp_rv2", 32'(rvalid), 32'b100); chk("fp_rd2", rdata[2], 32'hBBBB);
    @(negedge clk); drv = '0;
    #1 chk("fp_idle", 32'(rvalid), 0);
    // unmapped address
    @(negedge clk); req = 3'b010; addr[1] = 32'h30000;
    #1 chk("um_gnt", 32'(gnt), 32'b010); chk("um_dreq", 32'(dreq), 0);
    @(negedge clk); req = '0;
    #1 chk("um_rv", 32'(rvalid), 32'b010); chk("um_err", 32'(err), 32'b010);
    chk("um_rdata", rdata[1], 0);
    @(negedge clk);
    #1 chk("um_done", 32'(rvalid), 0);
    // outstanding limit and in-order return
    req = 3'b001; addr[0] = 32'h100;
    #1 chk("mo_g0", 32'(gnt), 32'b001);
    @(negedge clk); req = 3'b010; addr[1] = 32'h200;
    #1 chk("mo_g1", 32'(gnt), 32'b010);
    @(negedge clk); req = 3'b100; addr[2] = 32'h300;
    #1 chk("mo_full_gnt", 32'(gnt), 0); chk("mo_full_dreq", 32'(dreq), 0);
    @(negedge clk); drv = 2'b01; drdata[0] = 32'h1111;
    #1 chk("mo_pop_gnt", 32'(gnt), 0); chk("mo_rv0", 32'(rvalid), 32'b001);
    chk("mo_rd0", rdata[0], 32'h1111);
    @(negedge clk); drdata[0] = 32'h2222;
    #1 chk("mo_g2", 32'(gnt), 32'b100); chk("mo_rv1", 32'(rvalid), 32'b010);
    chk("mo_rd1", rdata[1], 32'h2222);
    @(negedge clk); req = '0; drdata[0] = 32'h3333;
    #1 chk("mo_rv2", 32'(rvalid), 32'b100); chk("mo_rd2", rdata[2], 32'h3333);
    @(negedge clk); drv = '0;
    // interleaved write to TestUtil with error, then RAM read
    req = 3'b011; addr[0] = 32'h20000; we[0] = 1'b1; addr[1] = 32'h500;
    #1 chk("il_g0", 32'(gnt), 32'b001); chk("il_dreq1", 32'(dreq), 32'b10);
    chk("il_we", 32'(dwe[1]), 1);
    @(negedge clk); req = 3'b010; we[0] = 1'b0;
    #1 chk("il_g1", 32'(gnt), 32'b010); chk("il_dreq0", 32'(dreq), 32'b01);
    chk("il_rv_none", 32'(rvalid), 0);
    @(negedge clk); req = '0; drv = 2'b10; derr = 2'b10;
    #1 chk("il_rv0", 32'(rvalid), 32'b001); chk("il_err0", 32'(err), 32'b001);
    @(negedge clk); drv = 2'b01; derr = 2'b00; drdata[0] = 32'h5555;
    #1 chk("il_rv1", 32'(rvalid), 32'b010); chk("il_err1", 32'(err), 0);
    chk("il_rd1", rdata[1], 32'h5555);
    @(negedge clk); drv = '0;
    // reset with two outstanding
    req = 3'b011; addr[0] = 32'h10; addr[1] = 32'h20;
    #1 chk("rs_g0", 32'(gnt), 32'b001);
    @(negedge clk); req = 3'b010;
    #1 chk("rs_g1", 32'(gnt), 32'b010);
    @(negedge clk); req = '0; drv = 2'b01; drdata[0] = 32'h7777;
    #1 chk("rs_rv_pre", 32'(rvalid), 32'b001);
    rst_ni = 1'b0;
    #1 chk("rs_rv_async", 32'(rvalid), 0);
    @(negedge clk);
    #1 chk("rs_stale", 32'(rvalid), 0);
    drv = '0; rst_ni = 1'b1;
    @(negedge clk);
    #1 chk("rs_after", 32'(rvalid), 0);
    // round robin, all hosts requesting continuously
    rr_req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1 chk($sformatf("rr_%0d", i), 32'(rr_gnt), 32'(3'b001 << (i % 3)));
      @(negedge clk);
    end
    rr_req = 3'b101;
    #1 chk("rr_skip0", 32'(rr_gnt), 32'b001);
    @(negedge clk);
    #1 chk("rr_skip2", 32'(rr_gnt), 32'b100);
    @(negedge clk); rr_req = '0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
